// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: frame geometry and frame-state encoding.
// Used by both the master and the converter side of the F0/C4 link.
package tdm_pkg;

   localparam int BITS_PER_FRAME  = 32;
   localparam int SLOTS_PER_FRAME = 2 * BITS_PER_FRAME + 1;
   localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);

   typedef logic [SLOT_W-1:0] slot_t;

   typedef enum logic [1:0] {
      IDLE,
      GAP,
      DATA
   } tdm_state_e;

endpackage

// File: rtl/tdm_clk_gen.sv
// C4 bit-clock divider with one-cycle fall/rise strobes.
// A strobe is high in the clk50 cycle whose closing edge moves c4.
module tdm_clk_gen #(
   parameter int CLK_DIV = 6
) (
   input  logic clk50,
   input  logic reset_n,
   output logic c4,
   output logic c4_fall,
   output logic c4_rise
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap    = (cnt == LAST);
   assign c4_fall = wrap & c4;
   assign c4_rise = wrap & ~c4;

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         c4  <= 1'b0;
      end else if (wrap) begin
         cnt <= '0;
         c4  <= ~c4;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/tdm_frame_master.sv
// Master end of the F0/C4 TDM link: frame gating, word serialise/deserialise,
// and 8-frame buffer marking. All state advances on the C4 strobes.
module tdm_frame_master
   import tdm_pkg::*;
#(
   parameter int CLK_DIV        = 6,
   parameter int FRAMES_PER_BUF = 8,
   parameter logic [BITS_PER_FRAME-1:0] IDLE_WORD = '0
) (
   input  logic                              clk50,
   input  logic                              reset_n,
   input  logic                              run,
   input  logic [BITS_PER_FRAME-1:0]         tx_data,
   input  logic                              tx_valid,
   output logic                              tx_ready,
   output logic                              tx_underrun,
   output logic [BITS_PER_FRAME-1:0]         rx_data,
   output logic                              rx_valid,
   output logic [$clog2(FRAMES_PER_BUF)-1:0] frame_idx,
   output logic                              buffer_done,
   output logic                              c4_o,
   output logic                              f0_o,
   output logic                              tdm_tx,
   input  logic                              tdm_rx
);

   localparam int FW = $clog2(FRAMES_PER_BUF);
   localparam slot_t LAST_SLOT = slot_t'(SLOTS_PER_FRAME - 1);
   localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES_PER_BUF - 1);

   tdm_state_e state, state_nx;
   slot_t      slot, slot_nx;
   logic       load;
   logic       c4, c4_fall, c4_rise;
   logic       sample, rx_pend;

   logic [BITS_PER_FRAME-1:0] tx_sh;
   logic [BITS_PER_FRAME-1:0] rx_sh;
   logic [FW-1:0]             fcnt;

   tdm_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk50   (clk50),
      .reset_n (reset_n),
      .c4      (c4),
      .c4_fall (c4_fall),
      .c4_rise (c4_rise)
   );

   always_comb begin
      state_nx = state;
      slot_nx  = slot;
      load     = 1'b0;
      if (c4_fall) begin
         unique case (state)
            IDLE: begin
               if (run) begin
                  state_nx = GAP;
                  slot_nx  = '0;
                  load     = 1'b1;
               end
            end
            GAP: begin
               state_nx = DATA;
               slot_nx  = slot_t'(1);
            end
            DATA: begin
               if (slot != LAST_SLOT) begin
                  slot_nx = slot + 1'b1;
               end else if (run) begin
                  state_nx = GAP;
                  slot_nx  = '0;
                  load     = 1'b1;
               end else begin
                  state_nx = IDLE;
                  slot_nx  = '0;
               end
            end
            default: begin
               state_nx = IDLE;
               slot_nx  = '0;
            end
         endcase
      end
   end

   // Even data slots carry the returned bits; slot 64 holds the last one.
   assign sample = c4_rise & (state == DATA) & ~slot[0];

   assign c4_o        = c4 & (state != IDLE);
   assign f0_o        = (state == DATA);
   assign tx_ready    = load & tx_valid;
   assign tx_underrun = load & ~tx_valid;

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         slot  <= '0;
      end else begin
         state <= state_nx;
         slot  <= slot_nx;
      end
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         tx_sh  <= '0;
         tdm_tx <= 1'b0;
      end else if (load) begin
         tx_sh  <= tx_valid ? tx_data : IDLE_WORD;
         tdm_tx <= 1'b0;
      end else if (c4_fall) begin
         if (state_nx == DATA && slot_nx[0]) begin
            tdm_tx <= tx_sh[0];
            tx_sh  <= {1'b0, tx_sh[BITS_PER_FRAME-1:1]};
         end else if (state_nx != DATA) begin
            tdm_tx <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         rx_sh       <= '0;
         rx_pend     <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         buffer_done <= 1'b0;
         frame_idx   <= '0;
         fcnt        <= '0;
      end else begin
         if (sample) begin
            rx_sh <= {tdm_rx, rx_sh[BITS_PER_FRAME-1:1]};
         end
         rx_pend     <= sample & (slot == LAST_SLOT);
         rx_valid    <= rx_pend;
         buffer_done <= rx_pend & (fcnt == LAST_FRAME);
         if (rx_pend) begin
            rx_data   <= rx_sh;
            frame_idx <= fcnt;
            fcnt      <= (fcnt == LAST_FRAME) ? '0 : fcnt + 1'b1;
         end
      end
   end

endmodule
